// File: rtl/vga_pixel_fetch.sv
// ---------------------------------------------------------------------------
// vga_pixel_fetch
//
// Pixel fetch stage behind the display timing generator. It turns the
// generator's active-video window into read addresses for a down-scaled
// frame buffer. Each stored pixel is replicated 2^SCALE_SHIFT times in both
// directions. The stage also delays sync/enable so they line up with the
// returned VRAM data, and registers the final RGB.
//
// Ports
//   pclk         in   pixel clock
//   rst          in   synchronous, active-low reset
//   hen, ven     in   horizontal / vertical active from the timing generator
//   hs, vs       in   syncs from the timing generator (polarity untouched)
//   vram_addr    out  AW   read address, driven from registers only
//   vram_data    in   DW   read data, RD_LAT cycles after its address
//   rgb          out  DW   registered pixel, 0 outside active video
//   de_o         out       data enable aligned with rgb
//   hs_o, vs_o   out       syncs delayed by L = RD_LAT+1
//   frame_start  out       one-cycle pulse on the first de_o of a frame
// ---------------------------------------------------------------------------
module vga_pixel_fetch #(
   parameter int HRES        = 800,
   parameter int VRES        = 600,
   parameter int SCALE_SHIFT = 2,
   parameter int FB_W        = 200,
   parameter int FB_H        = 150,
   parameter int AW          = 15,
   parameter int DW          = 12,
   parameter int RD_LAT      = 2
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          hen,
   input  logic          ven,
   input  logic          hs,
   input  logic          vs,
   output logic [AW-1:0] vram_addr,
   input  logic [DW-1:0] vram_data,
   output logic [DW-1:0] rgb,
   output logic          de_o,
   output logic          hs_o,
   output logic          vs_o,
   output logic          frame_start
);

   // Total output delay: RD_LAT cycles of VRAM plus the rgb register.
   localparam int L = RD_LAT + 1;
   // col must hold FB_W as well: it steps once more on the last pixel of a
   // line before the line-end clear takes effect.
   localparam int COL_W = (FB_W > 1) ? $clog2(FB_W + 1) : 1;

   // Geometry sanity check at elaboration time.
   if ((HRES != (FB_W << SCALE_SHIFT)) || (VRES != (FB_H << SCALE_SHIFT)) ||
       (RD_LAT < 1) || (SCALE_SHIFT < 1) || (FB_W * FB_H > (1 << AW)) ||
       (COL_W > AW)) begin : g_cfg_err
      $error("vga_pixel_fetch: inconsistent geometry parameters");
   end

   // ------------------------------------------------------------------
   // Scan state
   // ------------------------------------------------------------------
   logic [SCALE_SHIFT-1:0] hsub_q, hsub_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic [SCALE_SHIFT-1:0] vsub_q, vsub_d;
   logic [AW-1:0]          row_base_q, row_base_d;
   logic                   act_d_q;
   logic                   armed_q, armed_d;

   // Delay lines; bit 0 is the newest sample, bit L-1 drives the output.
   logic [L-1:0]           act_pipe_q, act_pipe_d;
   logic [L-1:0]           hs_pipe_q, hs_pipe_d;
   logic [L-1:0]           vs_pipe_q, vs_pipe_d;
   logic [L-1:0]           tag_pipe_q, tag_pipe_d;
   logic [DW-1:0]          rgb_q, rgb_d;

   logic act;
   logic line_end;
   logic tag;

   assign act      = hen & ven;
   // Falling edge of act inside the vertical active region.
   assign line_end = act_d_q & ~act & ven;
   // First active pixel after a vertical blank marks the frame start.
   assign tag      = act & armed_q;

   // ------------------------------------------------------------------
   // Counter next-state
   // ------------------------------------------------------------------
   always_comb begin
      hsub_d     = hsub_q;
      col_d      = col_q;
      vsub_d     = vsub_q;
      row_base_d = row_base_q;
      armed_d    = armed_q;

      if (!ven) begin
         // Vertical blank wins over a coincident line end.
         hsub_d     = '0;
         col_d      = '0;
         vsub_d     = '0;
         row_base_d = '0;
         armed_d    = 1'b1;
      end else if (line_end) begin
         hsub_d = '0;
         col_d  = '0;
         // vsub is exactly SCALE_SHIFT bits, so it wraps on its own.
         vsub_d = vsub_q + SCALE_SHIFT'(1);
         if (vsub_q == {SCALE_SHIFT{1'b1}}) begin
            row_base_d = row_base_q + AW'(FB_W);
         end
      end else if (act) begin
         hsub_d = hsub_q + SCALE_SHIFT'(1);
         if (hsub_q == {SCALE_SHIFT{1'b1}}) begin
            col_d = col_q + COL_W'(1);
         end
         if (armed_q) begin
            armed_d = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Delay line and data path next-state
   // ------------------------------------------------------------------
   always_comb begin
      act_pipe_d = {act_pipe_q[L-2:0], act};
      hs_pipe_d  = {hs_pipe_q[L-2:0],  hs};
      vs_pipe_d  = {vs_pipe_q[L-2:0],  vs};
      tag_pipe_d = {tag_pipe_q[L-2:0], tag};
      // act_pipe_q[RD_LAT-1] is the act of the address whose data is
      // arriving this cycle.
      rgb_d      = act_pipe_q[RD_LAT-1] ? vram_data : '0;
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (!rst) begin
         hsub_q     <= '0;
         col_q      <= '0;
         vsub_q     <= '0;
         row_base_q <= '0;
         act_d_q    <= 1'b0;
         armed_q    <= 1'b0;
         act_pipe_q <= '0;
         hs_pipe_q  <= '0;
         vs_pipe_q  <= '0;
         tag_pipe_q <= '0;
         rgb_q      <= '0;
      end else begin
         hsub_q     <= hsub_d;
         col_q      <= col_d;
         vsub_q     <= vsub_d;
         row_base_q <= row_base_d;
         act_d_q    <= act;
         armed_q    <= armed_d;
         act_pipe_q <= act_pipe_d;
         hs_pipe_q  <= hs_pipe_d;
         vs_pipe_q  <= vs_pipe_d;
         tag_pipe_q <= tag_pipe_d;
         rgb_q      <= rgb_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // Address depends on registers only, so it never sees an input glitch.
   assign vram_addr   = row_base_q + AW'(col_q);
   assign rgb         = rgb_q;
   assign de_o        = act_pipe_q[L-1];
   assign hs_o        = hs_pipe_q[L-1];
   assign vs_o        = vs_pipe_q[L-1];
   assign frame_start = tag_pipe_q[L-1];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch on a reduced 40x20 geometry (10x5 frame buffer,
// 4x replication, RD_LAT=2) so whole frames fit in a short run.
module tb_vga_pixel_fetch;
   localparam int HRES = 40, VRES = 20, SS = 2, FB_W = 10, FB_H = 5;
   localparam int AW = 6, DW = 12, RD_LAT = 2, L = RD_LAT + 1;
   localparam int H_TOT = 52, V_TOT = 24;

   logic          pclk = 1'b0;
   logic          rst = 1'b0, hen = 1'b0, ven = 1'b0, hs = 1'b1, vs = 1'b1;
   logic [AW-1:0] vram_addr;
   logic [DW-1:0] vram_data, rgb;
   logic          de_o, hs_o, vs_o, frame_start;
   logic [AW-1:0] ap1, ap2;

   vga_pixel_fetch #(
      .HRES(HRES), .VRES(VRES), .SCALE_SHIFT(SS), .FB_W(FB_W), .FB_H(FB_H),
      .AW(AW), .DW(DW), .RD_LAT(RD_LAT)
   ) dut (
      .pclk(pclk), .rst(rst), .hen(hen), .ven(ven), .hs(hs), .vs(vs),
      .vram_addr(vram_addr), .vram_data(vram_data), .rgb(rgb),
      .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .frame_start(frame_start)
   );

   always #5 pclk = ~pclk;

   // VRAM model: two-cycle read, content = {~addr, addr}.
   always @(posedge pclk) begin
      ap1 <= vram_addr;
      ap2 <= ap1;
   end
   assign vram_data = {~ap2, ap2};

   int   tests_run = 0, fails = 0, cyc = 0, cur = 0;
   logic h_act[8], h_hs[8], h_vs[8], h_tag[8], h_kn[8];
   int   h_addr[8];
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_rgb;
   logic o_de, o_hs, o_vs, o_fs;
   logic tb_armed = 1'b0, tb_known = 1'b0;

   function automatic int rix(input int c);
      return ((c % 8) + 8) % 8;
   endfunction

   // Drive one cycle, record what the outputs should show L cycles later,
   // and capture the outputs of this cycle at the falling edge.
   task automatic step(input logic rv, h, v, hsy, vsy, tg, kn, input int ea);
      int i;
      rst = rv; hen = h; ven = v; hs = hsy; vs = vsy;
      i = rix(cyc);
      h_act[i] = rv & h & v; h_hs[i] = rv & hsy; h_vs[i] = rv & vsy;
      h_tag[i] = tg; h_kn[i] = kn; h_addr[i] = ea;
      if (!rv) begin
         // Reset flushes everything already in flight.
         for (int k = 1; k < L; k++) begin
            h_act[rix(cyc - k)] = 1'b0; h_hs[rix(cyc - k)] = 1'b0;
            h_vs[rix(cyc - k)]  = 1'b0; h_tag[rix(cyc - k)] = 1'b0;
         end
      end
      @(negedge pclk);
      o_addr = vram_addr; o_rgb = rgb; o_de = de_o;
      o_hs = hs_o; o_vs = vs_o; o_fs = frame_start;
      @(posedge pclk); #1;
      cur = cyc;
      cyc++;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'b0, 1'b0, 0);
         if (k >= 1) begin
            tests_run++;
            if (o_rgb !== '0 || o_de !== 1'b0 || o_hs !== 1'b0 ||
                o_vs !== 1'b0 || o_fs !== 1'b0) begin
               fails++;
               $display("FAIL reset_outputs cyc=%0d got rgb=%h de=%b hs=%b vs=%b fs=%b exp all 0",
                        cur, o_rgb, o_de, o_hs, o_vs, o_fs);
            end
            tests_run++;
            if (o_addr !== '0) begin
               fails++;
               $display("FAIL reset_addr cyc=%0d got=%0d exp=0", cur, o_addr);
            end
         end
      end
      tb_armed = 1'b0;
      tb_known = 1'b0;
   endtask

   // One frame: 4 blank lines (vs low on lines 21-22) then 20 active lines.
   // hs is low for x=42..46. rst_line/rst_px inject a 2-cycle reset.
   task automatic test_frame(input int rst_line, input int rst_px);
      int   fs_cnt, y, ea, d;
      logic h, v, hsy, vsy, rv, a, tg, chk, prev_blank_ok, prev_rst_low;
      logic [AW-1:0] ed;
      logic [DW-1:0] erg;
      fs_cnt = 0; prev_blank_ok = 1'b0; prev_rst_low = 1'b0;
      for (int li = 0; li < V_TOT; li++) begin
         y = (li + VRES) % V_TOT;
         for (int x = 0; x < H_TOT; x++) begin
            h   = (x < HRES);
            v   = (y < VRES);
            hsy = !(x >= 42 && x < 47);
            vsy = !(y >= 21 && y < 23);
            rv  = !(y == rst_line && x >= rst_px && x < rst_px + 2);
            a   = h & v;
            tg  = rv & a & tb_armed;
            chk = rv & tb_known;
            ea  = a ? (y >> SS) * FB_W + (x >> SS) : 0;
            step(rv, h, v, hsy, vsy, tg, chk & a, ea);

            if (a && chk) begin
               tests_run++;
               if (o_addr !== AW'(ea)) begin
                  fails++;
                  $display("FAIL addr line=%0d px=%0d got=%0d exp=%0d", y, x, o_addr, ea);
               end
            end
            if (!v && prev_blank_ok) begin
               tests_run++;
               if (o_addr !== '0) begin
                  fails++;
                  $display("FAIL blank_addr line=%0d px=%0d got=%0d exp=0", y, x, o_addr);
               end
            end
            if (prev_rst_low) begin
               tests_run++;
               if (o_addr !== '0) begin
                  fails++;
                  $display("FAIL rst_addr line=%0d px=%0d got=%0d exp=0", y, x, o_addr);
               end
            end

            d = rix(cur - L);
            tests_run++;
            if (o_de !== h_act[d]) begin
               fails++;
               $display("FAIL de_o line=%0d px=%0d got=%b exp=%b", y, x, o_de, h_act[d]);
            end
            tests_run++;
            if (o_hs !== h_hs[d] || o_vs !== h_vs[d]) begin
               fails++;
               $display("FAIL sync line=%0d px=%0d got hs=%b vs=%b exp hs=%b vs=%b",
                        y, x, o_hs, o_vs, h_hs[d], h_vs[d]);
            end
            tests_run++;
            if (o_fs !== h_tag[d]) begin
               fails++;
               $display("FAIL frame_start line=%0d px=%0d got=%b exp=%b", y, x, o_fs, h_tag[d]);
            end
            if (!h_act[d] || h_kn[d]) begin
               ed  = AW'(h_addr[d]);
               erg = h_act[d] ? {~ed, ed} : '0;
               tests_run++;
               if (o_rgb !== erg) begin
                  fails++;
                  $display("FAIL rgb line=%0d px=%0d got=%h exp=%h", y, x, o_rgb, erg);
               end
            end
            if (o_fs) fs_cnt++;

            prev_blank_ok = rv & !v;
            prev_rst_low  = !rv;
            if (!rv) begin
               tb_armed = 1'b0;
               tb_known = 1'b0;
            end else if (!v) begin
               tb_armed = 1'b1;
               tb_known = 1'b1;
            end else if (tg) begin
               tb_armed = 1'b0;
            end
         end
      end
      tests_run++;
      if (fs_cnt != 1) begin
         fails++;
         $display("FAIL frame_start_count got=%0d exp=1", fs_cnt);
      end
   endtask

   initial begin
      @(posedge pclk); #1;
      test_reset();
      test_frame(-1, -1);   // first frame after reset
      test_frame(-1, -1);   // back-to-back frame
      test_frame(10, 20);   // reset mid-frame at line 10, pixel 20
      test_frame(-1, -1);   // resynchronised frame
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
